// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus generator/arbiter slice.
package bus_pkg;

  typedef enum logic {IDLE, DELIVER} bus_state_t;

  localparam int ID_W = 8;
  // Widest packet dest_id() accepts; callers zero-extend to this width.
  localparam int MAX_PKT_W = 256;

  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                              input int sz);
    return pkt[sz-1 -: ID_W];
  endfunction

endpackage

// File: rtl/bus_generator_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after last_grant wins.
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest offset so the nearest requester is assigned last.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % N);
      if (req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus generator: pops one packet round-robin and routes it by destination ID.
// Optional broadcast routing is enabled by defining BUS_BCAST_EN.
module bus_generator_arbiter
  import bus_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}}
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   D_push
);

  localparam int IDX_W = $clog2(drvrs);
`ifdef BUS_BCAST_EN
  localparam bit BCAST_EN = 1'b1;
`else
  localparam bit BCAST_EN = 1'b0;
`endif

  bus_state_t                    state, state_n;
  logic [IDX_W-1:0]              last_grant, last_grant_n;
  logic [IDX_W-1:0]              src, src_n;
  logic [IDX_W-1:0]              grant_idx;
  logic                          grant_vld;
  logic [pckg_sz-1:0]            pkt, pkt_n;
  logic [drvrs-1:0]              pop_n, push_n;
  logic [drvrs-1:0][pckg_sz-1:0] d_push_n;
  logic [ID_W-1:0]               dest;

  rr_arbiter #(.N(drvrs)) u_arb (
    .req       (pndng),
    .last_grant(last_grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign dest = dest_id(MAX_PKT_W'(pkt), pckg_sz);

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    src_n        = src;
    pkt_n        = pkt;
    pop_n        = '0;
    push_n       = '0;
    d_push_n     = D_push;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_n          = DELIVER;
          pkt_n            = D_pop[grant_idx];
          src_n            = grant_idx;
          last_grant_n     = grant_idx;
          pop_n[grant_idx] = 1'b1;
        end
      end
      DELIVER: begin
        state_n = IDLE;
        // Out-of-range IDs match no lane, so the packet is dropped.
        for (int j = 0; j < drvrs; j++) begin
          d_push_n[j] = pkt;
          if (BCAST_EN && (dest == broadcast))
            push_n[j] = (IDX_W'(j) != src);
          else
            push_n[j] = (dest == ID_W'(j));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(drvrs - 1);
      src        <= '0;
      pkt        <= '0;
      pop        <= '0;
      push       <= '0;
      D_push     <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      src        <= src_n;
      pkt        <= pkt_n;
      pop        <= pop_n;
      push       <= push_n;
      D_push     <= d_push_n;
    end
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Scoreboard bench for bus_generator_arbiter (drvrs=4, pckg_sz=16, broadcast=8'hFF).
module tb_bus_generator_arbiter;

  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] data;
  } exp_t;

`ifdef BUS_BCAST_EN
  localparam logic [3:0] BCAST_MASK = 4'b1101;
`else
  localparam logic [3:0] BCAST_MASK = 4'b0000;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        pndng;
  logic [3:0][15:0]  d_pop;
  logic [3:0]        pop;
  logic [3:0]        push;
  logic [3:0][15:0]  d_push;

  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;
  int   last_pop_cycle = 0;
  int   prev_pop = -1;
  int   rr_pops = 0;
  bit   rr_mode = 1'b0;
  int   exp_pop_q[$];
  exp_t exp_push_q[$];
  int   mon_g;
  exp_t mon_e;

  bus_generator_arbiter #(.drvrs(4), .pckg_sz(16), .broadcast(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .pndng (pndng),
    .D_pop (d_pop),
    .pop   (pop),
    .push  (push),
    .D_push(d_push)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Issue one packet from a single device; the pop and push expectations go to the scoreboard.
  task automatic applyStimulus(input int dev, input logic [15:0] data, input logic [3:0] mask);
    @(negedge clk);
    d_pop[dev] = data;
    pndng = 4'(1 << dev);
    exp_pop_q.push_back(dev);
    if (mask != 4'b0000) exp_push_q.push_back({mask, data});
    @(negedge clk);
    pndng = '0;
    @(negedge clk);
    if (mask == 4'b0000) begin
      checkOutput("drop_push", push, 0);
      checkOutput("drop_dpush_lane0", d_push[0], data);
    end
    @(negedge clk);
  endtask

  // Monitor: compares every pop/push the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (pop !== 4'b0000) begin
        if (exp_pop_q.size() == 0) begin
          checkOutput("pop_unexpected", pop, 0);
        end else begin
          mon_g = exp_pop_q.pop_front();
          checkOutput("pop_grant", pop, 64'(1 << mon_g));
          if (rr_mode) begin
            rr_pops++;
            if (prev_pop >= 0) checkOutput("pop_spacing", 64'(cycle - prev_pop), 2);
            prev_pop = cycle;
          end
          last_pop_cycle = cycle;
        end
      end
      if (push !== 4'b0000) begin
        if (exp_push_q.size() == 0) begin
          checkOutput("push_unexpected", push, 0);
        end else begin
          mon_e = exp_push_q.pop_front();
          checkOutput("push_mask", push, mon_e.mask);
          checkOutput("push_latency", 64'(cycle - last_pop_cycle), 1);
          for (int j = 0; j < 4; j++)
            checkOutput($sformatf("push_lane%0d", j), d_push[j], mon_e.data);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    pndng = '0;
    d_pop = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_pop", pop, 0);
    checkOutput("reset_push", push, 0);
    checkOutput("reset_dpush", d_push, 0);
    reset = 1'b0;

    applyStimulus(0, 16'h02A5, 4'b0100);
    applyStimulus(1, 16'hFF3C, BCAST_MASK);
    applyStimulus(3, 16'h0711, 4'b0000);
    applyStimulus(2, 16'h0299, 4'b0100);

    // Reset lands while pop[1] is high: the latched packet must never be pushed.
    @(negedge clk);
    d_pop[1] = 16'h0055;
    pndng = 4'b0010;
    exp_pop_q.push_back(1);
    @(negedge clk);
    #1 reset = 1'b1;
    pndng = '0;
    @(negedge clk);
    checkOutput("midreset_pop", pop, 0);
    checkOutput("midreset_push", push, 0);
    checkOutput("midreset_dpush", d_push, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midreset_late_push", push, 0);
    // After reset the scan restarts at device 0 even though 1 and 3 also request.
    d_pop[0] = 16'h03B0;
    d_pop[3] = 16'h01B3;
    pndng = 4'b1011;
    exp_pop_q.push_back(0);
    exp_push_q.push_back({4'b1000, 16'h03B0});
    @(negedge clk);
    pndng = '0;
    repeat (2) @(negedge clk);

    // Continuous requests from all devices rotate 0,1,2,3,0 at one pop per 2 cycles.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d_pop = {16'h00A3, 16'h03A2, 16'h02A1, 16'h01A0};
    rr_mode = 1'b1;
    prev_pop = -1;
    exp_pop_q.push_back(0); exp_push_q.push_back({4'b0010, 16'h01A0});
    exp_pop_q.push_back(1); exp_push_q.push_back({4'b0100, 16'h02A1});
    exp_pop_q.push_back(2); exp_push_q.push_back({4'b1000, 16'h03A2});
    exp_pop_q.push_back(3); exp_push_q.push_back({4'b0001, 16'h00A3});
    exp_pop_q.push_back(0); exp_push_q.push_back({4'b0010, 16'h01A0});
    pndng = 4'b1111;
    repeat (9) @(negedge clk);
    pndng = '0;
    repeat (3) @(negedge clk);

    checkOutput("rr_pop_count", rr_pops, 5);
    checkOutput("pop_queue_empty", exp_pop_q.size(), 0);
    checkOutput("push_queue_empty", exp_push_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
